// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
//   state_t      : arbiter FSM states
//   MAX_PKT      : default bytes per grant before a forced release
//   STALL_MAX    : default cycles a granted source may stall before abort
//   GAP_CYC      : default idle cycles between packets
//   clog2()      : ceil(log2(v)), never less than 1, for sizing counters
package uart_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, SEND, GAP} state_t;

  localparam int MAX_PKT   = 16;
  localparam int STALL_MAX = 65535;
  localparam int GAP_CYC   = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the message sources / byte transmitter and the arbiter.
//   req_valid/req_data/req_last : per-source byte offer (source i owns
//                                 req_data[i*DATA_W +: DATA_W])
//   req_ready                   : one-cycle accept pulse to the owner
//   grant                       : one-hot owner, zero when released
//   tx_start/tx_data/tx_busy    : transmitter launch interface
//   pkt_abort                   : stall-timeout pulse
//   arb_busy                    : arbiter not idle
// master = environment side (sources + transmitter), slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        grant;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_busy;
  logic                    pkt_abort;
  logic                    arb_busy;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_start, tx_data, pkt_abort, arb_busy
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_start, tx_data, pkt_abort, arb_busy
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker.
//   req    : request vector
//   ptr    : index with highest priority this round
//   onehot : winner, first set bit scanning ptr, ptr+1, ... mod N_REQ
//   any    : at least one request present
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic             any
);

  logic [PW-1:0] j;

  always_comb begin
    onehot = '0;
    any    = 1'b0;
    j      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = PW'((int'(ptr) + i) % N_REQ);
      if (!any && req[j]) begin
        onehot[j] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte transmitter between N_REQ sources.
// A granted source keeps the transmitter until its last byte, MAX_PKT bytes,
// or STALL_MAX cycles without a byte (aborted). Each release is followed by
// GAP_CYC idle cycles before the next arbitration.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_tx_arbiter_if.slave (sources + transmitter handshake)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_PKT   = uart_arb_pkg::MAX_PKT,
  parameter int STALL_MAX = uart_arb_pkg::STALL_MAX,
  parameter int GAP_CYC   = uart_arb_pkg::GAP_CYC
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int PW = clog2(N_REQ);
  localparam int BW = clog2(MAX_PKT + 1);
  localparam int SW = clog2(STALL_MAX + 1);
  localparam int GW = clog2(GAP_CYC + 1);

  localparam logic [BW-1:0] BYTE_MAX   = BW'(MAX_PKT);
  localparam logic [SW-1:0] STALL_TOP  = SW'(STALL_MAX);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t              state, state_n;
  logic [N_REQ-1:0]    grant_q, grant_n;
  logic [PW-1:0]       gidx, gidx_n, rr_ptr, rr_ptr_n;
  logic [BW-1:0]       byte_cnt, byte_n;
  logic [SW-1:0]       stall_cnt, stall_n;
  logic [GW-1:0]       gap_cnt, gap_n;
  logic [DATA_W-1:0]   tx_data_q, tx_data_n;
  logic                tx_start_q, start_n, acc_q;
  logic                last_q, last_n, abort_q, abort_n, busy_q, rel;

  logic [N_REQ-1:0]    pick_oh;
  logic                pick_any;
  logic [PW-1:0]       pick_idx;
  logic                cur_valid, cur_last;
  logic [DATA_W-1:0]   cur_data;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .any    (pick_any)
  );

  // Encode the winner and select the owner's lane.
  always_comb begin
    pick_idx  = '0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) pick_idx = PW'(i);
      if (gidx == PW'(i)) begin
        cur_valid = bus.req_valid[i];
        cur_last  = bus.req_last[i];
        cur_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant_q;
    gidx_n    = gidx;
    rr_ptr_n  = rr_ptr;
    byte_n    = byte_cnt;
    stall_n   = stall_cnt;
    gap_n     = gap_cnt;
    tx_data_n = tx_data_q;
    last_n    = last_q;
    start_n   = 1'b0;
    abort_n   = 1'b0;
    rel       = 1'b0;
    case (state)
      IDLE: if (pick_any) begin
        grant_n = pick_oh;
        gidx_n  = pick_idx;
        byte_n  = '0;
        stall_n = '0;
        state_n = GRANT;
      end
      GRANT: begin
        // A valid byte always wins over a stall timeout in the same cycle.
        if (cur_valid) begin
          if (!bus.tx_busy) begin
            start_n   = 1'b1;
            tx_data_n = cur_data;
            last_n    = cur_last;
            byte_n    = (byte_cnt == BYTE_MAX) ? byte_cnt : byte_cnt + 1'b1;
            stall_n   = '0;
            state_n   = SEND;
          end
        end else begin
          stall_n = (stall_cnt == STALL_TOP) ? stall_cnt : stall_cnt + 1'b1;
          if (stall_cnt >= STALL_LAST) begin
            abort_n = 1'b1;
            rel     = 1'b1;
          end
        end
      end
      SEND: begin
        // The launch cycle itself is skipped: tx_busy rises a cycle late.
        if (!tx_start_q && !bus.tx_busy) begin
          if (last_q || byte_cnt == BYTE_MAX) rel = 1'b1;
          else                                state_n = GRANT;
        end
      end
      GAP: begin
        if (GAP_CYC == 0 || gap_cnt == GAP_LAST) begin
          gap_n   = '0;
          state_n = IDLE;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (rel) begin
      grant_n  = '0;
      rr_ptr_n = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
      gap_n    = '0;
      state_n  = GAP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_q    <= '0;
      gidx       <= '0;
      rr_ptr     <= '0;
      byte_cnt   <= '0;
      stall_cnt  <= '0;
      gap_cnt    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      acc_q      <= 1'b0;
      last_q     <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      grant_q    <= grant_n;
      gidx       <= gidx_n;
      rr_ptr     <= rr_ptr_n;
      byte_cnt   <= byte_n;
      stall_cnt  <= stall_n;
      gap_cnt    <= gap_n;
      tx_data_q  <= tx_data_n;
      tx_start_q <= start_n;
      acc_q      <= start_n;
      last_q     <= last_n;
      abort_q    <= abort_n;
      busy_q     <= (state_n != IDLE);
    end
  end

  assign bus.grant     = grant_q;
  assign bus.req_ready = acc_q ? grant_q : '0;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.pkt_abort = abort_q;
  assign bus.arb_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int BUSY_CYC = 10;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] g;
    logic [7:0] d;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [3:0] r;
    logic [7:0] d;
    int         cyc;
  } tx_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_fail = 0, cyc = 0, bcnt = 0, rdy_err = 0, abort_cnt = 0;
  bit   busy_force = 1'b0;

  logic [8:0] src_q[N][$];
  tx_rec_t    txlog[$];
  vec_t       vecs[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

  uart_tx_arbiter #(
    .N_REQ(N), .DATA_W(W), .MAX_PKT(16), .STALL_MAX(100), .GAP_CYC(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_rec(input int k, input logic [3:0] g, input logic [7:0] d, input string nm);
    if (k < txlog.size()) begin
      check({nm, "_grant"}, 32'(txlog[k].g), 32'(g));
      check({nm, "_ready"}, 32'(txlog[k].r), 32'(g));
      check({nm, "_data"},  32'(txlog[k].d), 32'(d));
    end else begin
      check({nm, "_present"}, 32'(txlog.size()), 32'(k + 1));
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    for (int i = 0; i < budget && txlog.size() < n; i++) @(negedge clk);
    check(nm, 32'(txlog.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget, input string nm);
    for (int i = 0; i < budget && (bus.arb_busy !== 1'b0 || bus.tx_busy !== 1'b0); i++)
      @(negedge clk);
    check(nm, 32'(bus.arb_busy), 32'(0));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_grant"},     32'(bus.grant),     32'(0));
    check({nm, "_req_ready"}, 32'(bus.req_ready), 32'(0));
    check({nm, "_tx_start"},  32'(bus.tx_start),  32'(0));
    check({nm, "_tx_data"},   32'(bus.tx_data),   32'(0));
    check({nm, "_pkt_abort"}, 32'(bus.pkt_abort), 32'(0));
    check({nm, "_arb_busy"},  32'(bus.arb_busy),  32'(0));
  endtask

  // Transmitter: busy for BUSY_CYC cycles after each launch.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) bcnt = BUSY_CYC;
      else if (bcnt > 0)         bcnt--;
      bus.tx_busy = (bcnt != 0) || busy_force;
    end
  end

  // Sources: present queue head, pop on ready.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i] === 1'b1 && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          bus.req_valid[i]         = 1'b1;
          bus.req_data[i*W +: W]   = src_q[i][0][7:0];
          bus.req_last[i]          = src_q[i][0][8];
        end else begin
          bus.req_valid[i]         = 1'b0;
          bus.req_data[i*W +: W]   = '0;
          bus.req_last[i]          = 1'b0;
        end
      end
    end
  end

  // Launch log plus ready/abort bookkeeping.
  initial forever begin
    @(negedge clk);
    if (bus.tx_start === 1'b1)
      txlog.push_back('{g: bus.grant, r: bus.req_ready, d: bus.tx_data, cyc: cyc});
    if (bus.req_ready !== '0 && bus.tx_start !== 1'b1) rdy_err++;
    if (bus.pkt_abort === 1'b1) abort_cnt++;
  end

  initial begin
    int gapc, bad, abort_cyc, t0, a0, n0;
    vecs[0] = '{4'b0101, 4'b0001, 8'h40};
    vecs[1] = '{4'b0101, 4'b0100, 8'h42};
    vecs[2] = '{4'b0011, 4'b0001, 8'h40};
    vecs[3] = '{4'b1000, 4'b1000, 8'h43};
    vecs[4] = '{4'b1110, 4'b0010, 8'h41};
    vecs[5] = '{4'b1011, 4'b1000, 8'h43};
    vecs[6] = '{4'b0010, 4'b0010, 8'h41};
    vecs[7] = '{4'b0011, 4'b0001, 8'h40};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Round-robin table: one single-byte packet per requesting source.
    for (int v = 0; v < 8; v++) begin
      txlog.delete();
      for (int i = 0; i < N; i++)
        if (vecs[v].mask[i]) src_q[i].push_back({1'b1, 8'h40 + 8'(i)});
      wait_log(1, 60, $sformatf("vec%0d_tx", v));
      check_rec(0, vecs[v].g, vecs[v].d, $sformatf("vec%0d", v));
      for (int i = 0; i < N; i++) src_q[i].delete();
      wait_idle(200, $sformatf("vec%0d_idle", v));
    end

    // Source 1 sends "12"; grant held, then a 32-cycle gap.
    txlog.delete();
    src_q[1].push_back({1'b0, 8'h31});
    src_q[1].push_back({1'b1, 8'h32});
    wait_log(2, 80, "t1_tx");
    check_rec(0, 4'b0010, 8'h31, "t1_b0");
    check_rec(1, 4'b0010, 8'h32, "t1_b1");
    gapc = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.arb_busy !== 1'b1) break;
      if (bus.grant === 4'b0000)      gapc++;
      else if (bus.grant !== 4'b0010) bad++;
    end
    check("t1_gap_cycles", 32'(gapc), 32'(32));
    check("t1_grant_hold", 32'(bad), 32'(0));
    wait_idle(50, "t1_idle");

    // Stall: source 1 sends one byte then goes quiet.
    txlog.delete();
    a0 = abort_cnt;
    src_q[1].push_back({1'b0, 8'h77});
    wait_log(1, 60, "stall_tx");
    check_rec(0, 4'b0010, 8'h77, "stall_b0");
    t0 = (txlog.size() > 0) ? txlog[0].cyc : 0;
    abort_cyc = -1000;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.pkt_abort === 1'b1) begin
        abort_cyc = cyc;
        break;
      end
    end
    // 10 busy cycles, 100 stall cycles, then the registered pulse.
    check("stall_abort_delay", 32'(abort_cyc - t0), 32'(111));
    check("stall_grant_clear", 32'(bus.grant), 32'(0));
    @(negedge clk);
    check("stall_abort_width", 32'(bus.pkt_abort), 32'(0));
    check("stall_abort_count", 32'(abort_cnt - a0), 32'(1));
    txlog.delete();
    src_q[1].push_back({1'b1, 8'h88});
    src_q[2].push_back({1'b1, 8'h99});
    wait_log(2, 200, "stall_next_tx");
    check_rec(0, 4'b0100, 8'h99, "stall_next0");
    check_rec(1, 4'b0010, 8'h88, "stall_next1");
    wait_idle(200, "stall_idle");

    // Sources 0 and 2 valid from reset with 3-byte packets.
    txlog.delete();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      src_q[0].push_back({k == 2, 8'hA0 + 8'(k)});
      src_q[2].push_back({k == 2, 8'hC0 + 8'(k)});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_log(6, 400, "t2_tx");
    for (int k = 0; k < 3; k++) begin
      check_rec(k,     4'b0001, 8'hA0 + 8'(k), $sformatf("t2_s0_%0d", k));
      check_rec(k + 3, 4'b0100, 8'hC0 + 8'(k), $sformatf("t2_s2_%0d", k));
    end
    src_q[0].push_back({1'b1, 8'hD0});
    src_q[2].push_back({1'b1, 8'hE0});
    wait_log(8, 200, "t2_again_tx");
    check_rec(6, 4'b0001, 8'hD0, "t2_again0");
    check_rec(7, 4'b0100, 8'hE0, "t2_again1");
    wait_idle(200, "t2_idle");

    // Source 3 streams 20 bytes without last; source 0 joins mid-packet.
    txlog.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    a0 = abort_cnt;
    for (int k = 0; k < 20; k++) src_q[3].push_back({1'b0, 8'h80 + 8'(k)});
    wait_log(1, 60, "t3_first");
    src_q[0].push_back({1'b0, 8'h10});
    src_q[0].push_back({1'b1, 8'h11});
    wait_log(22, 1500, "t3_tx");
    for (int k = 0; k < 16; k++) check_rec(k, 4'b1000, 8'h80 + 8'(k), $sformatf("t3_a%0d", k));
    check_rec(16, 4'b0001, 8'h10, "t3_s0_0");
    check_rec(17, 4'b0001, 8'h11, "t3_s0_1");
    for (int k = 0; k < 4; k++) check_rec(18 + k, 4'b1000, 8'h90 + 8'(k), $sformatf("t3_b%0d", k));
    check("t3_no_abort_at_limit", 32'(abort_cnt - a0), 32'(0));
    for (int i = 0; i < 300 && abort_cnt == a0; i++) @(negedge clk);
    check("t3_tail_abort", 32'(abort_cnt - a0), 32'(1));
    wait_idle(100, "t3_idle");

    // Reset during SEND while the transmitter is still busy.
    txlog.delete();
    src_q[0].push_back({1'b1, 8'h5A});
    wait_log(1, 60, "rst_tx");
    repeat (2) @(negedge clk);
    check("rst_busy_before", 32'(bus.tx_busy), 32'(1));
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    busy_force = 1'b1;
    src_q[0].push_back({1'b1, 8'h55});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n0 = txlog.size();
    repeat (20) @(negedge clk);
    check("rst_no_start_while_busy", 32'(txlog.size()), 32'(n0));
    check("rst_regrant", 32'(bus.grant), 32'(4'b0001));
    busy_force = 1'b0;
    wait_log(n0 + 1, 60, "rst_resume_tx");
    check_rec(n0, 4'b0001, 8'h55, "rst_resume");
    wait_idle(200, "rst_idle");

    check("ready_only_with_tx_start", 32'(rdy_err), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
